// File: rtl/serial_deserializer.sv
// MSB-first serial-to-parallel receiver with framed bit counting, a one-entry
// valid/ready output buffer, a sticky overrun flag and a truncated-frame pulse.
module serial_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame,
    input  logic                  bit_en,
    input  logic                  data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  err_clr,
    output logic [1:0]            state_dbg
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT    = 2'd1,
        S_WAIT_END = 2'd2
    } state_t;

    // Handshake: data_out is transferred on any rising edge where valid && ready;
    // valid only falls after such a transfer and data_out is stable while valid.

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;

    logic [DATA_WIDTH-1:0] shifted;
    logic                  complete;
    logic                  drop;

    assign shifted = {sr_q[DATA_WIDTH-2:0], data_in};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        frame_err_d = 1'b0;
        complete    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (frame) begin
                    state_d = S_SHIFT;
                    if (bit_en) begin
                        sr_d  = shifted;
                        cnt_d = CW'(1);
                    end
                end
            end
            S_SHIFT: begin
                if (!frame) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else if (bit_en) begin
                    sr_d = shifted;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        complete = 1'b1;
                        state_d  = S_WAIT_END;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_WAIT_END: begin
                // Extra bits after a full word are ignored until frame falls.
                if (!frame) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop    = 1'b0;
        if (complete) begin
            // A same-cycle consume frees the buffer for the new word.
            if (!valid_q || ready) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        overrun_d = (overrun_q && !err_clr) || drop;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: directed scenarios plus random framed traffic,
// checked every cycle against a queue-based behavioural receiver model.
module tb_serial_deserializer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset, frame, bit_en, data_in, ready, err_clr;
    logic [DW-1:0] data_out;
    logic          valid, busy, overrun, frame_err;
    logic [1:0]    state_dbg;

    serial_deserializer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .frame(frame), .bit_en(bit_en), .data_in(data_in),
        .data_out(data_out), .valid(valid), .ready(ready), .busy(busy),
        .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int busy_cnt = 0;
    bit cmp_en = 1'b0;
    bit rnd_side = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame collects bits into a queue; once DW bits are
    // held the word is offered to a one-slot mailbox.
    logic          m_bits[$];
    bit            m_in_frame, m_have_word;
    logic [DW-1:0] m_data;
    logic          m_valid, m_busy, m_ovr, m_ferr;

    always @(posedge clk) begin
        bit       done;
        bit       lost;
        int       word;
        m_ferr = 1'b0;
        if (reset) begin
            m_in_frame = 0; m_have_word = 0; m_bits.delete();
            m_data = '0; m_valid = 0; m_busy = 0; m_ovr = 0;
        end else begin
            done = 0;
            lost = 0;
            if (!m_in_frame) begin
                if (frame) begin
                    m_in_frame = 1; m_have_word = 0; m_bits.delete();
                    if (bit_en) m_bits.push_back(data_in);
                end
            end else if (!frame) begin
                if (!m_have_word) m_ferr = 1'b1;
                m_in_frame = 0;
            end else if (!m_have_word && bit_en) begin
                m_bits.push_back(data_in);
                if (m_bits.size() == DW) begin
                    done = 1; m_have_word = 1;
                end
            end
            if (done) begin
                word = 0;
                foreach (m_bits[i]) word = word * 2 + int'(m_bits[i]);
                if (!m_valid || ready) begin
                    m_data = DW'(word); m_valid = 1'b1;
                end else begin
                    lost = 1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            m_ovr  = (m_ovr && !err_clr) || lost;
            m_busy = m_in_frame;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("data_out", 32'(data_out), 32'(m_data));
            chk("valid", 32'(valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
        end
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic step();
        if (rnd_side) begin
            ready   = 1'($urandom_range(0, 1));
            err_clr = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
    endtask

    // rmode 0: ready left untouched, 1: ready high only in the last bit cycle.
    task automatic send_word(input logic [DW-1:0] w, input int stride, input int rmode);
        for (int i = 0; i < DW; i++) begin
            for (int g = 0; g < ((i == 0) ? 0 : stride - 1); g++) begin
                frame = 1; bit_en = 0; data_in = 1'($urandom_range(0, 1));
                if (rmode == 1) ready = 0;
                step();
            end
            frame = 1; bit_en = 1; data_in = w[DW-1-i];
            if (rmode == 1) ready = (i == DW - 1);
            step();
        end
        frame = 0; bit_en = 0;
        if (rmode == 1) ready = 0;
        step();
    endtask

    task automatic pulse_ready();
        ready = 1; step(); ready = 0;
    endtask

    initial begin
        int target, got, extra;
        reset = 1; frame = 0; bit_en = 0; data_in = 0; ready = 0; err_clr = 0;
        step();
        cmp_en = 1;
        step();
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 0;
        step();

        busy_cnt = 0;
        send_word(8'hA5, 1, 0);
        chk("t1_data", 32'(data_out), 32'hA5);
        chk("t1_model", 32'(m_data), 32'hA5);
        chk("t1_valid", 32'(valid), 32'h1);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("t1_overrun", 32'(overrun), 32'h0);

        pulse_ready();
        send_word(8'hA5, 3, 0);
        chk("t2_data", 32'(data_out), 32'hA5);
        chk("t2_valid", 32'(valid), 32'h1);
        pulse_ready();
        chk("t2_valid_drop", 32'(valid), 32'h0);

        send_word(8'h11, 1, 0);
        send_word(8'h22, 2, 0);
        chk("t3_data", 32'(data_out), 32'h11);
        chk("t3_overrun", 32'(overrun), 32'h1);
        chk("t3_model_ovr", 32'(m_ovr), 32'h1);
        err_clr = 1; step(); err_clr = 0;
        chk("t3_ovr_clr", 32'(overrun), 32'h0);
        chk("t3_valid", 32'(valid), 32'h1);

        send_word(8'h33, 1, 1);
        chk("t4_data", 32'(data_out), 32'h33);
        chk("t4_valid", 32'(valid), 32'h1);
        chk("t4_overrun", 32'(overrun), 32'h0);

        pulse_ready();
        for (int i = 0; i < 3; i++) begin
            frame = 1; bit_en = 1; data_in = 1'(i); step();
        end
        frame = 0; bit_en = 0; step();
        chk("t5_ferr", 32'(frame_err), 32'h1);
        chk("t5_valid", 32'(valid), 32'h0);
        step();
        chk("t5_ferr_once", 32'(frame_err), 32'h0);
        send_word(8'hC3, 1, 0);
        chk("t5_data", 32'(data_out), 32'hC3);

        pulse_ready();
        send_word(8'h55, 1, 0);
        chk("t6_buf", 32'(data_out), 32'h55);
        for (int i = 0; i < 4; i++) begin
            frame = 1; bit_en = 1; data_in = 1'(i % 2); step();
        end
        reset = 1; step(); reset = 0;
        chk("t6_rst_data", 32'(data_out), 32'h0);
        chk("t6_rst_valid", 32'(valid), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        frame = 0; bit_en = 0; step();
        send_word(8'h3C, 1, 0);
        chk("t6_data", 32'(data_out), 32'h3C);

        rnd_side = 1;
        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(0, 29) == 0) begin
                reset = 1; step(); reset = 0;
            end
            target = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DW - 1)) : DW;
            got = 0;
            while (got < target) begin
                frame = 1; bit_en = ($urandom_range(0, 2) != 0);
                data_in = 1'($urandom_range(0, 1));
                step();
                if (bit_en) got++;
            end
            extra = $urandom_range(0, 2);
            for (int e = 0; e < extra; e++) begin
                frame = 1; bit_en = (target == DW) ? 1'($urandom_range(0, 1)) : 1'b0;
                data_in = 1'($urandom_range(0, 1));
                step();
            end
            frame = 0; bit_en = 1'($urandom_range(0, 1)); data_in = 1'($urandom_range(0, 1));
            step();
            bit_en = 0;
            if ($urandom_range(0, 1) == 1) step();
        end
        rnd_side = 0; ready = 0; err_clr = 0; frame = 0; bit_en = 0;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
